// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the RV32I multicycle control path: opcodes, FSM states,
// and the datapath mux/ALU select codes driven by multicycle_control_fsm.
package multicycle_control_fsm_pkg;

    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_RTYPE  = 7'b0110011,
        OP_ITYPE  = 7'b0010011,
        OP_BRANCH = 7'b1100011,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111
    } opcode_t;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_JALRADR  = 4'd12,
        S_LUI      = 4'd13,
        S_TRAP     = 4'd14
    } state_t;

    typedef enum logic [1:0] {
        RES_ALUOUT    = 2'b00,
        RES_DATA      = 2'b01,
        RES_ALURESULT = 2'b10
    } result_src_t;

    typedef enum logic [1:0] {
        SRCA_PC    = 2'b00,
        SRCA_OLDPC = 2'b01,
        SRCA_RS1   = 2'b10,
        SRCA_ZERO  = 2'b11
    } alu_src_a_t;

    typedef enum logic [1:0] {
        SRCB_RS2  = 2'b00,
        SRCB_IMM  = 2'b01,
        SRCB_FOUR = 2'b10
    } alu_src_b_t;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10
    } alu_op_t;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_src_t;

    typedef struct packed {
        logic        pc_update;
        logic        branch;
        logic        adr_src;
        logic        ir_write;
        logic        mem_write;
        logic        reg_write;
        result_src_t result_src;
        alu_src_a_t  alu_src_a;
        alu_src_b_t  alu_src_b;
        alu_op_t     alu_op;
        logic        instr_done;
        logic        illegal;
    } ctrl_t;

endpackage

// File: rtl/multicycle_control_fsm_imm_src_decode.sv
// Immediate-format select derived directly from the opcode field.
module imm_src_decode
    import multicycle_control_fsm_pkg::*;
(
    input  logic [6:0] opcode,
    output imm_src_t   imm_src
);

    // Opcode to immediate format; unknown opcodes fall back to I-type
    always_comb begin
        imm_src = IMM_I;
        case (opcode)
            OP_LOAD, OP_ITYPE, OP_JALR: imm_src = IMM_I;
            OP_STORE:                   imm_src = IMM_S;
            OP_BRANCH:                  imm_src = IMM_B;
            OP_JAL:                     imm_src = IMM_J;
            OP_LUI, OP_AUIPC:           imm_src = IMM_U;
            default:                    imm_src = IMM_I;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Moore control FSM for a multicycle RV32I datapath. Define MEM_HANDSHAKE_EN to
// make FETCH/MEMREAD/MEMWRITE wait on mem_ready_i; otherwise every state is one cycle.
module multicycle_control_fsm
    import multicycle_control_fsm_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode_i,
    input  logic       mem_ready_i,
    output logic       PCUpdate_o,
    output logic       Branch_o,
    output logic       AdrSrc_o,
    output logic       IRWrite_o,
    output logic       MemWrite_o,
    output logic       RegWrite_o,
    output logic [1:0] ResultSrc_o,
    output logic [1:0] ALUSrcA_o,
    output logic [1:0] ALUSrcB_o,
    output logic [1:0] ALUOp_o,
    output logic [2:0] ImmSrc_o,
    output logic       instr_done_o,
    output logic       illegal_o
);

    state_t   state_r;
    ctrl_t    ctrl_r;
    logic     mem_ready_s;
    logic     fetch_ok_s;
    imm_src_t imm_src_s;

`ifdef MEM_HANDSHAKE_EN
    assign mem_ready_s = mem_ready_i;
`else
    logic unused_mem_ready_s;
    assign mem_ready_s        = 1'b1;
    assign unused_mem_ready_s = mem_ready_i;
`endif

    function automatic state_t next_state_f(input state_t st, input logic [6:0] op,
                                            input logic ready);
        state_t ns;
        ns = S_TRAP;
        case (st)
            S_FETCH: begin
                if (ready) ns = S_DECODE;
                else       ns = S_FETCH;
            end
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: ns = S_MEMADR;
                    OP_RTYPE:          ns = S_EXECR;
                    OP_ITYPE:          ns = S_EXECI;
                    OP_BRANCH:         ns = S_BEQ;
                    OP_JAL:            ns = S_JAL;
                    OP_JALR:           ns = S_JALRADR;
                    OP_LUI:            ns = S_LUI;
                    OP_AUIPC:          ns = S_ALUWB;
                    default:           ns = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                if (op == OP_STORE) ns = S_MEMWRITE;
                else                ns = S_MEMREAD;
            end
            S_MEMREAD: begin
                if (ready) ns = S_MEMWB;
                else       ns = S_MEMREAD;
            end
            S_MEMWRITE: begin
                if (ready) ns = S_FETCH;
                else       ns = S_MEMWRITE;
            end
            S_EXECR, S_EXECI, S_JAL, S_JALR, S_LUI: ns = S_ALUWB;
            S_JALRADR:                              ns = S_JALR;
            S_MEMWB, S_ALUWB, S_BEQ:                ns = S_FETCH;
            S_TRAP:                                 ns = S_TRAP;
            default:                                ns = S_TRAP;
        endcase
        return ns;
    endfunction

    function automatic ctrl_t decode_ctrl(input state_t st);
        ctrl_t c;
        c = '0;
        case (st)
            S_FETCH: begin
                c.ir_write   = 1'b1;
                c.pc_update  = 1'b1;
                c.result_src = RES_ALURESULT;
                c.alu_src_b  = SRCB_FOUR;
            end
            // Speculatively form PC-relative target into ALUOut
            S_DECODE: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_IMM;
            end
            S_MEMADR, S_JALRADR: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: c.adr_src = 1'b1;
            S_MEMWB: begin
                c.result_src = RES_DATA;
                c.reg_write  = 1'b1;
                c.instr_done = 1'b1;
            end
            S_MEMWRITE: begin
                c.adr_src    = 1'b1;
                c.mem_write  = 1'b1;
                c.instr_done = 1'b1;
            end
            S_EXECR: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_op    = ALU_FUNCT;
            end
            S_EXECI: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALU_FUNCT;
            end
            S_LUI: begin
                c.alu_src_a = SRCA_ZERO;
                c.alu_src_b = SRCB_IMM;
            end
            S_ALUWB: begin
                c.reg_write  = 1'b1;
                c.instr_done = 1'b1;
            end
            S_BEQ: begin
                c.alu_src_a  = SRCA_RS1;
                c.alu_op     = ALU_SUB;
                c.branch     = 1'b1;
                c.instr_done = 1'b1;
            end
            // Link value PC+4 computed from OldPC while PC takes ALUOut
            S_JAL, S_JALR: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_FOUR;
                c.pc_update = 1'b1;
            end
            S_TRAP:  c.illegal = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    // State register with its control word registered alongside
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= S_FETCH;
            ctrl_r  <= decode_ctrl(S_FETCH);
        end else begin
            state_r <= next_state_f(state_r, opcode_i, mem_ready_s);
            ctrl_r  <= decode_ctrl(next_state_f(state_r, opcode_i, mem_ready_s));
        end
    end

    imm_src_decode u_imm_src_decode (
        .opcode  (opcode_i),
        .imm_src (imm_src_s)
    );

    // Fetch enables wait for memory; reset masks every architectural write
    assign fetch_ok_s   = (state_r != S_FETCH) | mem_ready_s;
    assign PCUpdate_o   = ctrl_r.pc_update & rst_n & fetch_ok_s;
    assign IRWrite_o    = ctrl_r.ir_write & rst_n & fetch_ok_s;
    assign Branch_o     = ctrl_r.branch & rst_n;
    assign MemWrite_o   = ctrl_r.mem_write & rst_n;
    assign RegWrite_o   = ctrl_r.reg_write & rst_n;
    assign AdrSrc_o     = ctrl_r.adr_src;
    assign ResultSrc_o  = ctrl_r.result_src;
    assign ALUSrcA_o    = ctrl_r.alu_src_a;
    assign ALUSrcB_o    = ctrl_r.alu_src_b;
    assign ALUOp_o      = ctrl_r.alu_op;
    assign instr_done_o = ctrl_r.instr_done;
    assign illegal_o    = ctrl_r.illegal;
    assign ImmSrc_o     = imm_src_s;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: stimulus queues per-cycle expected
// control words, a negedge monitor pops and compares them against the outputs.
module tb_multicycle_control_fsm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic       mem_ready;
    logic       pc_update, branch, adr_src, ir_write, mem_write, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
    logic [2:0] imm_src;
    logic       instr_done, illegal;

    int checks = 0;
    int fails  = 0;

    logic [18:0] exp_q [$];
    string       tag_q [$];

    // {PCUpdate,Branch,AdrSrc,IRWrite,MemWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUOp,done,illegal}
    localparam logic [15:0] C_FETCH    = 16'b1001_0010_0010_0000;
    localparam logic [15:0] C_RST      = 16'b0000_0010_0010_0000;
    localparam logic [15:0] C_DECODE   = 16'b0000_0000_0101_0000;
    localparam logic [15:0] C_MEMADR   = 16'b0000_0000_1001_0000;
    localparam logic [15:0] C_MEMREAD  = 16'b0010_0000_0000_0000;
    localparam logic [15:0] C_MEMWB    = 16'b0000_0101_0000_0010;
    localparam logic [15:0] C_MEMWRITE = 16'b0010_1000_0000_0010;
    localparam logic [15:0] C_EXECR    = 16'b0000_0000_1000_1000;
    localparam logic [15:0] C_EXECI    = 16'b0000_0000_1001_1000;
    localparam logic [15:0] C_LUI      = 16'b0000_0000_1101_0000;
    localparam logic [15:0] C_ALUWB    = 16'b0000_0100_0000_0010;
    localparam logic [15:0] C_BEQ      = 16'b0100_0000_1000_0110;
    localparam logic [15:0] C_JAL      = 16'b1000_0000_0110_0000;
    localparam logic [15:0] C_JALRADR  = 16'b0000_0000_1001_0000;
    localparam logic [15:0] C_TRAP     = 16'b0000_0000_0000_0001;

    multicycle_control_fsm dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .opcode_i     (opcode),
        .mem_ready_i  (mem_ready),
        .PCUpdate_o   (pc_update),
        .Branch_o     (branch),
        .AdrSrc_o     (adr_src),
        .IRWrite_o    (ir_write),
        .MemWrite_o   (mem_write),
        .RegWrite_o   (reg_write),
        .ResultSrc_o  (result_src),
        .ALUSrcA_o    (alu_src_a),
        .ALUSrcB_o    (alu_src_b),
        .ALUOp_o      (alu_op),
        .ImmSrc_o     (imm_src),
        .instr_done_o (instr_done),
        .illegal_o    (illegal)
    );

    always #5 clk = ~clk;

    // Monitor: compare the DUT outputs of each queued cycle mid-period
    always @(negedge clk) begin
        logic [18:0] act;
        logic [18:0] e;
        string       t;
        if (tag_q.size() != 0) begin
            e   = exp_q.pop_front();
            t   = tag_q.pop_front();
            act = {pc_update, branch, adr_src, ir_write, mem_write, reg_write,
                   result_src, alu_src_a, alu_src_b, alu_op, instr_done, illegal, imm_src};
            checks++;
            if (act !== e) begin
                fails++;
                $display("FAIL %s: got %b required %b", t, act, e);
            end
        end
    end

    task automatic cycle(input logic [15:0] c, input logic [2:0] imm, input string tag);
        exp_q.push_back({c, imm});
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic [6:0] op, input logic [2:0] imm, input string name,
                         input int n, input logic [15:0] s0, input logic [15:0] s1,
                         input logic [15:0] s2, input logic [15:0] s3, input logic [15:0] s4);
        logic [15:0] seq [5];
        seq[0] = s0; seq[1] = s1; seq[2] = s2; seq[3] = s3; seq[4] = s4;
        opcode = op;
        for (int i = 0; i < n; i++) cycle(seq[i], imm, $sformatf("%s_c%0d", name, i + 1));
    endtask

    initial begin
        rst_n     = 1'b0;
        opcode    = 7'b0000000;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        cycle(C_RST, 3'b000, "reset");
        rst_n = 1'b1;

        instr(7'b0000011, 3'b000, "load",   5, C_FETCH, C_DECODE, C_MEMADR, C_MEMREAD, C_MEMWB);
        instr(7'b0100011, 3'b001, "store",  4, C_FETCH, C_DECODE, C_MEMADR, C_MEMWRITE, 16'b0);
        instr(7'b0110011, 3'b000, "rtype",  4, C_FETCH, C_DECODE, C_EXECR, C_ALUWB, 16'b0);
        instr(7'b0010011, 3'b000, "itype",  4, C_FETCH, C_DECODE, C_EXECI, C_ALUWB, 16'b0);
        instr(7'b1100011, 3'b010, "branch", 3, C_FETCH, C_DECODE, C_BEQ, 16'b0, 16'b0);
        instr(7'b1101111, 3'b011, "jal",    4, C_FETCH, C_DECODE, C_JAL, C_ALUWB, 16'b0);
        instr(7'b1100111, 3'b000, "jalr",   5, C_FETCH, C_DECODE, C_JALRADR, C_JAL, C_ALUWB);
        instr(7'b0110111, 3'b100, "lui",    4, C_FETCH, C_DECODE, C_LUI, C_ALUWB, 16'b0);
        instr(7'b0010111, 3'b100, "auipc",  3, C_FETCH, C_DECODE, C_ALUWB, 16'b0, 16'b0);

        // Reset asserted while in MEMREAD returns to FETCH with writes masked
        instr(7'b0000011, 3'b000, "ldrst",  3, C_FETCH, C_DECODE, C_MEMADR, 16'b0, 16'b0);
        rst_n = 1'b0;
        cycle(C_MEMREAD, 3'b000, "ldrst_memread");
        cycle(C_RST, 3'b000, "ldrst_fetch_held");
        rst_n = 1'b1;
        cycle(C_FETCH, 3'b000, "ldrst_refetch");
        cycle(C_DECODE, 3'b000, "ldrst_decode");
        cycle(C_MEMADR, 3'b000, "ldrst_memadr");
        cycle(C_MEMREAD, 3'b000, "ldrst_memread2");
        cycle(C_MEMWB, 3'b000, "ldrst_memwb");

        // Unknown opcode traps until reset
        instr(7'b1111111, 3'b000, "illegal", 2, C_FETCH, C_DECODE, 16'b0, 16'b0, 16'b0);
        for (int i = 0; i < 20; i++) cycle(C_TRAP, 3'b000, $sformatf("trap_%0d", i));
        rst_n = 1'b0;
        cycle(C_TRAP, 3'b000, "trap_rst_cycle");
        cycle(C_RST, 3'b000, "trap_cleared");
        rst_n = 1'b1;
        instr(7'b0100011, 3'b001, "post_trap", 4, C_FETCH, C_DECODE, C_MEMADR, C_MEMWRITE, 16'b0);

`ifdef MEM_HANDSHAKE_EN
        // Fetch stalls three cycles, then the load completes normally
        opcode    = 7'b0000011;
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) cycle(C_RST, 3'b000, $sformatf("stall_%0d", i));
        mem_ready = 1'b1;
        instr(7'b0000011, 3'b000, "stall_ld", 5, C_FETCH, C_DECODE, C_MEMADR, C_MEMREAD, C_MEMWB);
`else
        // Without the handshake build mem_ready_i has no effect
        mem_ready = 1'b0;
        instr(7'b0000011, 3'b000, "noready_ld", 5, C_FETCH, C_DECODE, C_MEMADR, C_MEMREAD, C_MEMWB);
        mem_ready = 1'b1;
`endif

        for (int i = 0; i < 10 && tag_q.size() != 0; i++) @(negedge clk);
        if (tag_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d entries left, required 0", tag_q.size());
        end
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
